// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit count, glyph table, blank code and
// the frame record used by the display blocks.
package seg7_pkg;

    localparam int unsigned N_DIGITS = 8;

    // Active-low segment code for a fully dark digit.
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Active-low glyphs, bit order {a,b,c,d,e,f,g} with a in bit 6.
    localparam logic [6:0] SEG7_GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // One 8-digit frame: digit i is data[31-4i -: 4], blanked when blank[7-i].
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  blank;
    } seg7_frame_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder with a blank override.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins over the glyph lookup.
    always_comb begin
        seg_o = blank_i ? SEG7_BLANK : SEG7_GLYPH[nibble_i];
    end

endmodule

// File: rtl/seg7_frame_scheduler.sv
// Scan controller for an 8-digit common-anode display. Two requesters offer
// frames over valid/ready; a round-robin arbiter fills a one-deep pending
// buffer that is promoted to the displayed buffer only at a scan-frame
// boundary. Anodes and segments are registered and active-low.
module seg7_frame_scheduler
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [7:0]  req0_blank,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [7:0]  req1_blank,
    output logic        req1_ready,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done,
    output logic        active_src
);

    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Scan counters
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic             div_end;
    logic             boundary;

    // Frame buffers
    seg7_frame_t pend_q, pend_d;
    logic        pend_src_q, pend_src_d;
    logic        pend_full_q, pend_full_d;
    seg7_frame_t act_q, act_d;
    logic        act_src_q, act_src_d;
    logic        last_grant_q, last_grant_d;

    // Arbitration
    logic        grant_valid;
    logic        grant_src;
    logic        accept;
    seg7_frame_t offer0, offer1;

    // Output stage
    logic [3:0] digit_nibble;
    logic       digit_blank;
    logic [6:0] digit_glyph;
    logic [7:0] an_q, an_d;
    logic [6:0] seg_q;
    logic       frame_done_q;

    assign offer0 = '{data: req0_data, blank: req0_blank};
    assign offer1 = '{data: req1_data, blank: req1_blank};

    // Round-robin grant: a lone requester wins, a tie goes away from last_grant.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_src = ~last_grant_q;
        end else begin
            grant_src = req1_valid;
        end
        accept     = grant_valid & ~pend_full_q;
        req0_ready = ~rst & ~pend_full_q & grant_valid & ~grant_src;
        req1_ready = ~rst & ~pend_full_q & grant_valid &  grant_src;
    end

    // Prescaler and digit index; the last slot of digit 7 is the frame boundary.
    always_comb begin
        div_end  = (div_q == DIV_LAST);
        boundary = div_end && (idx_q == 3'd7);
        div_d    = div_end ? '0 : div_q + DIV_W'(1);
        idx_d    = div_end ? idx_q + 3'd1 : idx_q;
    end

    // Buffer update. Acceptance needs pend_full low, so a swap and a load never
    // compete for the pending buffer in the same cycle.
    always_comb begin
        pend_d       = pend_q;
        pend_src_d   = pend_src_q;
        pend_full_d  = pend_full_q;
        act_d        = act_q;
        act_src_d    = act_src_q;
        last_grant_d = last_grant_q;
        if (boundary && pend_full_q) begin
            act_d       = pend_q;
            act_src_d   = pend_src_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d       = grant_src ? offer1 : offer0;
            pend_src_d   = grant_src;
            pend_full_d  = 1'b1;
            last_grant_d = grant_src;
        end
    end

    // Select the displayed digit's nibble, blank flag and anode pattern.
    always_comb begin
        digit_nibble = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                digit_nibble = act_q.data[31 - 4*i -: 4];
            end
        end
        digit_blank          = act_q.blank[3'd7 - idx_q];
        an_d                 = '1;
        an_d[3'd7 - idx_q]   = 1'b0;
    end

    seg7_hex_decode u_decode (
        .nibble_i (digit_nibble),
        .blank_i  (digit_blank),
        .seg_o    (digit_glyph)
    );

    // State and registered outputs; reset darkens the display and drops frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_src_q   <= 1'b0;
            pend_full_q  <= 1'b0;
            act_q        <= '{data: '0, blank: '1};
            act_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
            an_q         <= '1;
            seg_q        <= SEG7_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_src_q   <= pend_src_d;
            pend_full_q  <= pend_full_d;
            act_q        <= act_d;
            act_src_q    <= act_src_d;
            last_grant_q <= last_grant_d;
            an_q         <= an_d;
            seg_q        <= digit_glyph;
            frame_done_q <= boundary;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;
    assign active_src = act_src_q;

endmodule

// File: tb/tb_seg7_frame_scheduler.sv
// Randomized bench for seg7_frame_scheduler against a frame-level model that
// derives scan position from elapsed cycles and tracks one pending frame.
module tb_seg7_frame_scheduler;

    localparam int unsigned SD = 4;
    localparam int unsigned FR = 8 * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic [7:0]  req0_blank, req1_blank;
    logic        req0_ready, req1_ready;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    logic        active_src;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_frame_scheduler #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_blank (req0_blank),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_blank (req1_blank),
        .req1_ready (req1_ready),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .active_src (active_src)
    );

    always #5 clk = ~clk;

    // Model state
    int unsigned k = 0;
    bit          model_live = 1'b0;
    bit          pend_v = 1'b0;
    logic [31:0] pend_d = '0, act_d = '0;
    logic [7:0]  pend_b = '0, act_b = 8'hFF;
    bit          pend_s = 1'b0, act_s = 1'b0, last_g = 1'b1;
    logic [7:0]  exp_an = 8'hFF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_fd = 1'b0, exp_src = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;  4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;  4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;  4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;  4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;  4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;  default: glyph = 7'b0111000;
        endcase
    endfunction

    // One clock: check last edge's outputs, apply inputs, check readies, advance model.
    task automatic cycle(input logic r, input logic v0, input logic [31:0] d0, input logic [7:0] b0,
                         input logic v1, input logic [31:0] d1, input logic [7:0] b1);
        bit          g_any, g_src, acc, bnd;
        int unsigned dig;
        logic [31:0] sh;
        @(negedge clk);
        if (model_live) begin
            check_eq("an", an, exp_an);
            check_eq("seg", seg, exp_seg);
            check_eq("frame_done", frame_done, exp_fd);
            check_eq("active_src", active_src, exp_src);
        end
        rst = r;
        req0_valid = v0; req0_data = d0; req0_blank = b0;
        req1_valid = v1; req1_data = d1; req1_blank = b1;
        #1;
        g_any = v0 | v1;
        g_src = (v0 && v1) ? ~last_g : v1;
        acc   = !r && !pend_v && g_any;
        check_eq("req0_ready", req0_ready, acc && !g_src);
        check_eq("req1_ready", req1_ready, acc && g_src);
        model_live = 1'b1;
        if (r) begin
            k = 0; pend_v = 0; act_d = '0; act_b = 8'hFF; act_s = 0; last_g = 1;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_fd = 0; exp_src = 0;
        end else begin
            dig     = (k % FR) / SD;
            bnd     = (k % FR) == FR - 1;
            exp_an  = ~(8'h80 >> dig);
            sh      = act_d >> (28 - 4 * dig);
            exp_seg = act_b[7 - dig] ? 7'h7F : glyph(sh[3:0]);
            exp_fd  = bnd;
            if (bnd && pend_v) begin
                act_d = pend_d; act_b = pend_b; act_s = pend_s; pend_v = 0;
            end
            if (acc) begin
                pend_v = 1; pend_s = g_src; last_g = g_src;
                pend_d = g_src ? d1 : d0;
                pend_b = g_src ? b1 : b0;
            end
            exp_src = act_s;
            k++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, '0);
    endtask

    // Idle until the next edge is at scan position pos within the frame.
    task automatic idle_to(input int unsigned pos);
        int guard = 0;
        while ((k % FR) != pos && guard < 2 * FR) begin
            cycle(0, 0, '0, '0, 0, '0, '0);
            guard++;
        end
        check_eq("align", k % FR, pos);
    endtask

    initial begin
        rst = 1; req0_valid = 0; req1_valid = 0;
        req0_data = '0; req1_data = '0; req0_blank = '0; req1_blank = '0;
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, '0, 0, '0, '0);
        // Dark scan with no frames.
        idle(2 * FR + 5);
        // Ordinary frame from requester 0.
        cycle(0, 1, 32'h0123_4567, 8'h00, 0, '0, '0);
        idle(2 * FR);
        // Acceptance coinciding with the boundary edge.
        idle_to(FR - 1);
        cycle(0, 0, '0, '0, 1, 32'hFFFF_FFFF, 8'h00);
        idle(2 * FR + 3);
        // Edge digits blanked.
        cycle(0, 1, 32'h8888_8888, 8'h81, 0, '0, '0);
        idle(2 * FR);
        // Both requesters always valid.
        for (int i = 0; i < 6 * FR; i++)
            cycle(0, 1, $urandom, 8'($urandom), 1, $urandom, 8'($urandom));
        // Random traffic with occasional reset.
        for (int i = 0; i < 30 * FR; i++)
            cycle(($urandom % 150) == 0,
                  $urandom_range(0, 1) == 1, $urandom, 8'($urandom),
                  $urandom_range(0, 1) == 1, $urandom, 8'($urandom));
        // Reset in the middle of digit 3 with a frame pending.
        idle(2 * FR);
        cycle(0, 1, 32'h1357_9BDF, 8'h00, 0, '0, '0);
        idle_to(3 * SD + 1);
        cycle(1, 0, '0, '0, 0, '0, '0);
        idle(2 * FR + 2);
        cycle(0, 0, '0, '0, 0, '0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
